// File: rtl/layer_train_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// layer_train_sequencer_if: request/valid handshake between sequencer and layer
// rev 1.0
// ----------------------------------------------------------------------------
interface layer_train_sequencer_if #(
  parameter int IDX_W = 1
) ();
  logic             zero_grad;
  logic             run_forward;
  logic             load_backward;
  logic             run_backward;
  logic             update;
  logic             valid_zero_grad;
  logic             valid_forward;
  logic             valid_backward;
  logic             valid_update;
  logic [IDX_W-1:0] fwd_idx;
  logic [IDX_W-1:0] bwd_idx;

  modport master (
    output zero_grad, run_forward, load_backward, run_backward, update,
    output fwd_idx, bwd_idx,
    input  valid_zero_grad, valid_forward, valid_backward, valid_update
  );

  modport slave (
    input  zero_grad, run_forward, load_backward, run_backward, update,
    input  fwd_idx, bwd_idx,
    output valid_zero_grad, valid_forward, valid_backward, valid_update
  );
endinterface
`default_nettype wire

// File: rtl/layer_train_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// layer_train_sequencer: drives one layer through forward/backward/update of a batch
// rev 1.0
// ----------------------------------------------------------------------------
module layer_train_sequencer #(
  parameter int BATCH_SIZE  = 4,
  parameter int IDX_W       = $clog2(BATCH_SIZE + 1),
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  layer_train_sequencer_if.master lyr,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_timeout_o
);

  localparam int               WD_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] c_batch   = IDX_W'(BATCH_SIZE);
  localparam logic [WD_W-1:0]  c_wd_last = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ZG    = 4'd1,
    S_SETUP = 4'd2,
    S_FWD0  = 4'd3,
    S_REL   = 4'd4,
    S_LOADB = 4'd5,
    S_PAIR  = 4'd6,
    S_LAST  = 4'd7,
    S_UPD   = 4'd8,
    S_FIN   = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] fwd_idx_q, fwd_idx_d;
  logic [IDX_W-1:0] bwd_idx_q, bwd_idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             seen_a_q, seen_a_d;
  logic             seen_f_q, seen_f_d;
  logic             err_q, err_d;

  logic w_zero_grad, w_run_forward, w_load_backward, w_run_backward, w_update;
  logic w_busy, w_done, w_req_state, w_wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fwd_idx_q <= '0;
      bwd_idx_q <= '0;
      wd_q      <= '0;
      seen_a_q  <= 1'b0;
      seen_f_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fwd_idx_q <= fwd_idx_d;
      bwd_idx_q <= bwd_idx_d;
      wd_q      <= wd_d;
      seen_a_q  <= seen_a_d;
      seen_f_q  <= seen_f_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fwd_idx_d       = fwd_idx_q;
    bwd_idx_d       = bwd_idx_q;
    seen_a_d        = seen_a_q;
    seen_f_d        = seen_f_q;
    err_d           = err_q;
    w_zero_grad     = 1'b0;
    w_run_forward   = 1'b0;
    w_load_backward = 1'b0;
    w_run_backward  = 1'b0;
    w_update        = 1'b0;
    w_busy          = 1'b1;
    w_done          = 1'b0;
    w_req_state     = 1'b0;
    w_wd_expired    = (wd_q == c_wd_last);

    case (state_q)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          state_d   = S_ZG;
          fwd_idx_d = '0;
          bwd_idx_d = '0;
          err_d     = 1'b0;
        end
      end
      S_ZG: begin
        w_zero_grad = 1'b1;
        state_d     = S_FWD0;
      end
      S_FWD0: begin
        w_zero_grad   = 1'b1;
        w_run_forward = 1'b1;
        w_req_state   = 1'b1;
        seen_a_d      = seen_a_q | lyr.valid_zero_grad;
        seen_f_d      = seen_f_q | lyr.valid_forward;
        if (seen_a_d && seen_f_d) begin
          state_d   = S_REL;
          fwd_idx_d = fwd_idx_q + IDX_W'(1);
        end else if (w_wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_REL: begin
        state_d = (bwd_idx_q < c_batch) ? S_LOADB : S_UPD;
      end
      S_LOADB: begin
        w_load_backward = 1'b1;
        state_d         = S_SETUP;
      end
      S_SETUP: begin
        state_d = (fwd_idx_q < c_batch) ? S_PAIR : S_LAST;
      end
      S_PAIR: begin
        // Both requests stay up until both results have been seen.
        w_run_forward  = 1'b1;
        w_run_backward = 1'b1;
        w_req_state    = 1'b1;
        seen_a_d       = seen_a_q | lyr.valid_backward;
        seen_f_d       = seen_f_q | lyr.valid_forward;
        if (seen_a_d && seen_f_d) begin
          state_d   = S_REL;
          fwd_idx_d = fwd_idx_q + IDX_W'(1);
          bwd_idx_d = bwd_idx_q + IDX_W'(1);
        end else if (w_wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_LAST: begin
        w_run_backward = 1'b1;
        w_req_state    = 1'b1;
        if (lyr.valid_backward) begin
          state_d   = S_REL;
          bwd_idx_d = bwd_idx_q + IDX_W'(1);
        end else if (w_wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_UPD: begin
        w_update    = 1'b1;
        w_req_state = 1'b1;
        if (lyr.valid_update) begin
          state_d = S_FIN;
        end else if (w_wd_expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_FIN: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        w_busy  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over start, valids and the watchdog; the error flag stays sticky.
    if (abort_i) begin
      state_d   = S_IDLE;
      fwd_idx_d = '0;
      bwd_idx_d = '0;
      err_d     = err_q;
    end

    if (state_d != state_q) begin
      seen_a_d = 1'b0;
      seen_f_d = 1'b0;
    end

    wd_d = (w_req_state && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
  end

  assign lyr.zero_grad     = w_zero_grad;
  assign lyr.run_forward   = w_run_forward;
  assign lyr.load_backward = w_load_backward;
  assign lyr.run_backward  = w_run_backward;
  assign lyr.update        = w_update;
  assign lyr.fwd_idx       = fwd_idx_q;
  assign lyr.bwd_idx       = bwd_idx_q;
  assign busy_o            = w_busy;
  assign done_o            = w_done;
  assign err_timeout_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_train_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_layer_train_sequencer: batch-schedule model check of two sequencers (B=2, B=1)
// rev 1.0
// ----------------------------------------------------------------------------
module tb_layer_train_sequencer;

  localparam int TO = 16;
  localparam int K_ZG = 0, K_FWD0 = 1, K_REL = 2, K_LOADB = 3, K_SETUP = 4;
  localparam int K_PAIR = 5, K_LAST = 6, K_UPD = 7, K_FIN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start_v, abort_v, busy_v, done_v, err_v;

  layer_train_sequencer_if #(.IDX_W(2)) if0 ();
  layer_train_sequencer_if #(.IDX_W(1)) if1 ();

  layer_train_sequencer #(.BATCH_SIZE(2), .IDX_W(2), .TIMEOUT_CYC(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .abort_i(abort_v[0]),
    .lyr(if0.master), .busy_o(busy_v[0]), .done_o(done_v[0]), .err_timeout_o(err_v[0]));

  layer_train_sequencer #(.BATCH_SIZE(1), .IDX_W(1), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .abort_i(abort_v[1]),
    .lyr(if1.master), .busy_o(busy_v[1]), .done_o(done_v[1]), .err_timeout_o(err_v[1]));

  // Responder: each valid rises dly cycles after its request rises and stays while it is held.
  int              age [2][4];
  int              dly [2][4];
  logic [1:0][3:0] req, vld;
  bit   [1:0][3:0] prevreq;

  assign req[0] = {if0.update, if0.run_backward, if0.run_forward, if0.zero_grad};
  assign req[1] = {if1.update, if1.run_backward, if1.run_forward, if1.zero_grad};

  genvar gk, gj;
  for (gk = 0; gk < 2; gk++) begin : g_resp
    for (gj = 0; gj < 4; gj++) begin : g_sig
      assign vld[gk][gj] = req[gk][gj] && (dly[gk][gj] != 0) && (age[gk][gj] >= dly[gk][gj]);
    end
  end

  assign if0.valid_zero_grad = vld[0][0];
  assign if0.valid_forward   = vld[0][1];
  assign if0.valid_backward  = vld[0][2];
  assign if0.valid_update    = vld[0][3];
  assign if1.valid_zero_grad = vld[1][0];
  assign if1.valid_forward   = vld[1][1];
  assign if1.valid_backward  = vld[1][2];
  assign if1.valid_update    = vld[1][3];

  // {fwd_idx, bwd_idx, zg, rf, lb, rb, up, busy, done, err}
  logic [1:0][11:0] outs;
  assign outs[0] = {if0.fwd_idx, if0.bwd_idx, if0.zero_grad, if0.run_forward, if0.load_backward,
                    if0.run_backward, if0.update, busy_v[0], done_v[0], err_v[0]};
  assign outs[1] = {1'b0, if1.fwd_idx, 1'b0, if1.bwd_idx, if1.zero_grad, if1.run_forward,
                    if1.load_backward, if1.run_backward, if1.update, busy_v[1], done_v[1], err_v[1]};

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  // Model: position in the batch schedule plus completed forward/backward counts.
  int bsz [2];
  bit m_act [2], m_err [2], m_sa [2], m_sf [2];
  int m_s [2], m_fwd [2], m_bwd [2], m_wd [2];

  // Event counters: zg rise, rf rise, rb rise, lb cycles, up rise, done cycles, rf&rb cycles, up cycles
  int              cnt [2][8];
  int              base [8];
  logic [1:0][11:0] prev_o;

  function automatic int kind_of(int s, int b);
    int j, it, pos;
    if (s == 0) return K_ZG;
    if (s == 1) return K_FWD0;
    j = s - 2; it = j / 4; pos = j % 4;
    if (it < b) begin
      if (pos == 0) return K_REL;
      if (pos == 1) return K_LOADB;
      if (pos == 2) return K_SETUP;
      return (it < b - 1) ? K_PAIR : K_LAST;
    end
    if (pos == 0) return K_REL;
    if (pos == 1) return K_UPD;
    return K_FIN;
  endfunction

  function automatic logic [11:0] expect_vec(int k);
    int   kd;
    logic zg, rf, lb, rb, up, bz, dn;
    {zg, rf, lb, rb, up, bz, dn} = '0;
    if (m_act[k]) begin
      kd = kind_of(m_s[k], bsz[k]);
      zg = (kd == K_ZG) || (kd == K_FWD0);
      rf = (kd == K_FWD0) || (kd == K_PAIR);
      lb = (kd == K_LOADB);
      rb = (kd == K_PAIR) || (kd == K_LAST);
      up = (kd == K_UPD);
      dn = (kd == K_FIN);
      bz = !dn;
    end
    return {2'(m_fwd[k]), 2'(m_bwd[k]), zg, rf, lb, rb, up, bz, dn, m_err[k]};
  endfunction

  task automatic model_reset(int k);
    m_act[k] = 0; m_err[k] = 0; m_sa[k] = 0; m_sf[k] = 0;
    m_s[k] = 0; m_fwd[k] = 0; m_bwd[k] = 0; m_wd[k] = 0;
  endtask

  task automatic model_step(int k);
    int kd;
    bit fin, req_kind;
    if (abort_v[k]) begin
      m_act[k] = 0; m_fwd[k] = 0; m_bwd[k] = 0; m_sa[k] = 0; m_sf[k] = 0; m_wd[k] = 0;
      return;
    end
    if (!m_act[k]) begin
      if (start_v[k]) begin
        m_act[k] = 1; m_s[k] = 0; m_fwd[k] = 0; m_bwd[k] = 0; m_err[k] = 0; m_wd[k] = 0;
      end
      return;
    end
    kd = kind_of(m_s[k], bsz[k]);
    fin = 0; req_kind = 1;
    case (kd)
      K_FWD0: begin
        m_sa[k] = m_sa[k] | vld[k][0];
        m_sf[k] = m_sf[k] | vld[k][1];
        fin = m_sa[k] && m_sf[k];
        if (fin) m_fwd[k]++;
      end
      K_PAIR: begin
        m_sa[k] = m_sa[k] | vld[k][2];
        m_sf[k] = m_sf[k] | vld[k][1];
        fin = m_sa[k] && m_sf[k];
        if (fin) begin m_fwd[k]++; m_bwd[k]++; end
      end
      K_LAST: begin
        fin = vld[k][2];
        if (fin) m_bwd[k]++;
      end
      K_UPD:  fin = vld[k][3];
      K_FIN:  begin m_act[k] = 0; req_kind = 0; end
      default: begin m_s[k]++; req_kind = 0; end
    endcase
    if (req_kind) begin
      if (fin) begin
        m_s[k]++; m_sa[k] = 0; m_sf[k] = 0; m_wd[k] = 0;
      end else if (m_wd[k] == TO - 1) begin
        m_err[k] = 1; m_act[k] = 0; m_sa[k] = 0; m_sf[k] = 0; m_wd[k] = 0;
      end else begin
        m_wd[k]++;
      end
    end
  endtask

  task automatic count_events(int k);
    if (outs[k][7] && !prev_o[k][7]) cnt[k][0]++;
    if (outs[k][6] && !prev_o[k][6]) cnt[k][1]++;
    if (outs[k][4] && !prev_o[k][4]) cnt[k][2]++;
    if (outs[k][5])                  cnt[k][3]++;
    if (outs[k][3] && !prev_o[k][3]) cnt[k][4]++;
    if (outs[k][1])                  cnt[k][5]++;
    if (outs[k][6] && outs[k][4])    cnt[k][6]++;
    if (outs[k][3])                  cnt[k][7]++;
    prev_o[k] = outs[k];
  endtask

  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    cyc_n++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      e = expect_vec(k);
      n_checks++;
      if (outs[k] !== e) begin
        n_err++;
        $display("FAIL cycle_outputs dut%0d cyc %0d: got %h expected %h", k, cyc_n, outs[k], e);
      end
      count_events(k);
      prevreq[k] = req[k];
      if (rst_n) model_step(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++)
        age[k][j] = (rst_n && prevreq[k][j]) ? age[k][j] + 1 : 0;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic snap(int k);
    for (int i = 0; i < 8; i++) base[i] = cnt[k][i];
  endtask

  function automatic int delta(int k, int i);
    return cnt[k][i] - base[i];
  endfunction

  task automatic run_batch(int k);
    int n;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    n = 0;
    while (busy_v[k] && n < 300) begin tick(); n++; end
    chk("batch_end_busy", int'(busy_v[k]), 0);
    tick();
    tick();
  endtask

  initial begin
    int n;
    bsz[0] = 2; bsz[1] = 1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      prevreq[k] = '0;
      prev_o[k]  = '0;
      for (int j = 0; j < 4; j++) begin age[k][j] = 0; dly[k][j] = 3; end
      for (int i = 0; i < 8; i++) cnt[k][i] = 0;
    end
    start_v = '0; abort_v = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("reset_outs_dut0", int'(outs[0]), 0);
    chk("reset_outs_dut1", int'(outs[1]), 0);
    rst_n = 1'b1;
    tick();

    // B=2, all responses at +3
    snap(0);
    run_batch(0);
    chk("b2_zero_grad_rises", delta(0, 0), 1);
    chk("b2_run_forward_rises", delta(0, 1), 2);
    chk("b2_run_backward_rises", delta(0, 2), 2);
    chk("b2_load_backward_pulses", delta(0, 3), 2);
    chk("b2_update_rises", delta(0, 4), 1);
    chk("b2_done_pulses", delta(0, 5), 1);
    chk("b2_fwd_idx_final", int'(outs[0][11:10]), 2);
    chk("b2_bwd_idx_final", int'(outs[0][9:8]), 2);

    // PAIR with forward at +2 and backward at +9: held together for 10 cycles
    dly[0][1] = 2; dly[0][2] = 9;
    snap(0);
    run_batch(0);
    chk("pair_overlap_cycles", delta(0, 6), 10);
    chk("pair_done_pulses", delta(0, 5), 1);
    dly[0][1] = 3; dly[0][2] = 3;

    // B=1: no overlap, a single update
    snap(1);
    run_batch(1);
    chk("b1_overlap_cycles", delta(1, 6), 0);
    chk("b1_update_rises", delta(1, 4), 1);
    chk("b1_done_pulses", delta(1, 5), 1);

    // Update never answered: watchdog fires after 16 update cycles
    dly[1][3] = 0;
    snap(1);
    run_batch(1);
    chk("to_err_timeout", int'(err_v[1]), 1);
    chk("to_update_cycles", delta(1, 7), 16);
    chk("to_no_done", delta(1, 5), 0);
    dly[1][3] = 3;
    snap(1);
    run_batch(1);
    chk("to_err_cleared_by_start", int'(err_v[1]), 0);
    chk("to_recover_done", delta(1, 5), 1);

    // Abort in PAIR
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    n = 0;
    while (!(outs[0][6] && outs[0][4]) && n < 100) begin tick(); n++; end
    chk("abort_reached_pair", int'(outs[0][6] && outs[0][4]), 1);
    tick();
    abort_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
    chk("abort_requests_low", int'(outs[0][7:3]), 0);
    chk("abort_busy_low", int'(busy_v[0]), 0);
    snap(0);
    run_batch(0);
    chk("abort_rerun_done", delta(0, 5), 1);
    chk("abort_rerun_updates", delta(0, 4), 1);

    // start pulse in FWD0 ignored, then async reset in LAST
    snap(0);
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    n = 0;
    while (!(outs[0][6] && outs[0][7]) && n < 100) begin tick(); n++; end
    chk("rst_reached_fwd0", int'(outs[0][6] && outs[0][7]), 1);
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    n = 0;
    while (!(outs[0][4] && !outs[0][6]) && n < 200) begin tick(); n++; end
    chk("rst_reached_last", int'(outs[0][4] && !outs[0][6]), 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outs", int'(outs[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", delta(0, 5), 0);
    chk("rst_single_zero_grad", delta(0, 0), 1);
    snap(0);
    run_batch(0);
    chk("rst_rerun_done", delta(0, 5), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
